// File: rtl/msg_dispatch_sched.sv
// msg_dispatch_sched: in-order scheduler streaming completed messages from the byte buffer to the field parser
module msg_dispatch_sched #(
  parameter int NUM_SLOTS  = 8,
  parameter int DATA_WIDTH = 5,
  parameter int BYTE_W     = 8,
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  store_start_i,
  input  logic                  store_end_i,
  input  logic [SLOT_W-1:0]     slot_i,
  input  logic [DATA_WIDTH-1:0] start_addr_i,
  input  logic [DATA_WIDTH-1:0] end_addr_i,
  output logic                  tbl_full_o,
  output logic                  tbl_empty_o,
  output logic                  err_o,
  output logic                  rd_en_o,
  output logic [DATA_WIDTH-1:0] rd_addr_o,
  input  logic [BYTE_W-1:0]     rd_data_i,
  output logic                  byte_valid_o,
  output logic [BYTE_W-1:0]     byte_data_o,
  output logic                  byte_last_o,
  output logic [SLOT_W-1:0]     msg_id_o,
  input  logic                  byte_ready_i,
  output logic                  release_valid_o,
  output logic [DATA_WIDTH-1:0] release_addr_o
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RELEASE} state_t;
  localparam logic [DATA_WIDTH-1:0] ONE_A = 1;
  localparam logic [SLOT_W-1:0]     ONE_S = 1;
  state_t                state_q, state_d;
  logic [NUM_SLOTS-1:0]  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] start_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] start_d [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] end_q [NUM_SLOTS];
  logic [DATA_WIDTH-1:0] end_d [NUM_SLOTS];
  logic [SLOT_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                  err_q, err_d, full_q, full_d, empty_q, empty_d;
  logic [DATA_WIDTH-1:0] cur_q, cur_d, last_addr_q, last_addr_d;
  logic                  inflight_q, inflight_d, infl_last_q, infl_last_d;
  logic [BYTE_W-1:0]     sk_data_q [2];
  logic [BYTE_W-1:0]     sk_data_d [2];
  logic [1:0]            sk_last_q, sk_last_d;
  logic                  sk_wr_q, sk_wr_d, sk_rd_q, sk_rd_d;
  logic [1:0]            sk_cnt_q, sk_cnt_d;
  logic                  store_hit, pop, at_end;
  // The skid head is presented directly; with an empty skid the byte arriving from the buffer bypasses it.
  assign store_hit       = (store_start_i | store_end_i) & valid_q[slot_i];
  assign byte_valid_o    = (sk_cnt_q != 2'd0) | inflight_q;
  assign byte_data_o     = (sk_cnt_q != 2'd0) ? sk_data_q[sk_rd_q] : (inflight_q ? rd_data_i : '0);
  assign byte_last_o     = (sk_cnt_q != 2'd0) ? sk_last_q[sk_rd_q] : infl_last_q;
  assign pop             = byte_valid_o & byte_ready_i;
  assign at_end          = cur_q == last_addr_q;
  assign rd_en_o         = (state_q == STREAM) && ((3'(sk_cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  assign rd_addr_o       = rd_en_o ? cur_q : '0;
  assign msg_id_o        = rd_ptr_q;
  assign release_valid_o = state_q == RELEASE;
  assign release_addr_o  = release_valid_o ? last_addr_q + ONE_A : '0;
  assign tbl_full_o      = full_q;
  assign tbl_empty_o     = empty_q;
  assign err_o           = err_q;
  // Next-state for the location table, scheduler FSM and skid buffer.
  always_comb begin
    valid_d = valid_q;
    start_d = start_q;
    end_d   = end_q;
    err_d   = err_q | store_hit;
    if (!store_hit) begin
      if (store_start_i) start_d[slot_i] = start_addr_i;
      if (store_end_i) begin
        end_d[slot_i]   = end_addr_i;
        valid_d[slot_i] = 1'b1;
      end
    end
    sk_data_d = sk_data_q;
    sk_last_d = sk_last_q;
    if (inflight_q) begin
      sk_data_d[sk_wr_q] = rd_data_i;
      sk_last_d[sk_wr_q] = infl_last_q;
    end
    sk_wr_d     = sk_wr_q ^ inflight_q;
    sk_rd_d     = sk_rd_q ^ pop;
    sk_cnt_d    = sk_cnt_q + 2'(inflight_q) - 2'(pop);
    inflight_d  = rd_en_o;
    infl_last_d = rd_en_o & at_end;
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    cur_d       = cur_q;
    last_addr_d = last_addr_q;
    case (state_q)
      IDLE: if (valid_q[rd_ptr_q]) begin
        cur_d       = start_q[rd_ptr_q];
        last_addr_d = end_q[rd_ptr_q];
        state_d     = STREAM;
      end
      STREAM: if (rd_en_o) begin
        cur_d   = cur_q + ONE_A;
        state_d = at_end ? DRAIN : STREAM;
      end
      DRAIN: if (pop && byte_last_o && sk_cnt_d == 2'd0) state_d = RELEASE;
      RELEASE: begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + ONE_S;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
    full_d  = &valid_d;
    empty_d = ~|valid_d;
  end
  // Control state; reset abandons any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      cur_q       <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      sk_wr_q     <= 1'b0;
      sk_rd_q     <= 1'b0;
      sk_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      cur_q       <= cur_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      sk_wr_q     <= sk_wr_d;
      sk_rd_q     <= sk_rd_d;
      sk_cnt_q    <= sk_cnt_d;
    end
  end
  // Address table and skid storage; contents are qualified by valid bits and skid count.
  always_ff @(posedge clk) begin
    start_q   <= start_d;
    end_q     <= end_d;
    sk_data_q <= sk_data_d;
    sk_last_q <= sk_last_d;
  end
endmodule

// File: tb/tb_msg_dispatch_sched.sv
// tb_msg_dispatch_sched: scoreboard bench for the message dispatch scheduler
module tb_msg_dispatch_sched;
  localparam int NS = 8, DW = 5, BW = 8, SW = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic store_start_i = 1'b0, store_end_i = 1'b0;
  logic [SW-1:0] slot_i = '0;
  logic [DW-1:0] start_addr_i = '0, end_addr_i = '0;
  logic tbl_full_o, tbl_empty_o, err_o, rd_en_o;
  logic [DW-1:0] rd_addr_o, release_addr_o;
  logic [BW-1:0] rd_data_i = '0, byte_data_o;
  logic byte_valid_o, byte_last_o, release_valid_o;
  logic [SW-1:0] msg_id_o;
  logic byte_ready_i = 1'b1;

  typedef struct packed {logic [SW-1:0] id; logic last; logic [BW-1:0] data;} exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] rel_q[$];
  logic [BW-1:0] mem [2**DW];
  int total = 0, bad = 0, mode = 0, cyc = 0, issued = 0, accepted = 0;
  logic pend = 1'b0;
  logic [DW-1:0] pend_addr = '0;
  logic prev_stall = 1'b0, prev_last = 1'b0, hs = 1'b0;
  logic [BW-1:0] prev_data = '0;
  exp_t e;

  msg_dispatch_sched #(.NUM_SLOTS(NS), .DATA_WIDTH(DW), .BYTE_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .store_start_i(store_start_i), .store_end_i(store_end_i),
    .slot_i(slot_i), .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
    .tbl_full_o(tbl_full_o), .tbl_empty_o(tbl_empty_o), .err_o(err_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .byte_valid_o(byte_valid_o), .byte_data_o(byte_data_o), .byte_last_o(byte_last_o),
    .msg_id_o(msg_id_o), .byte_ready_i(byte_ready_i),
    .release_valid_o(release_valid_o), .release_addr_o(release_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Byte buffer answers one cycle after a read; downstream ready follows the current mode.
  always @(posedge clk) begin
    #1;
    rd_data_i = pend ? mem[pend_addr] : '0;
    byte_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    cyc++;
  end

  // Monitor: scoreboard compare of bytes and releases, stall stability, read credit.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      prev_stall = 1'b0;
      issued = 0;
      accepted = 0;
    end else begin
      hs = byte_valid_o && byte_ready_i;
      if (prev_stall) begin
        chk("stall_valid", byte_valid_o, 1);
        chk("stall_data", byte_data_o, prev_data);
        chk("stall_last", byte_last_o, prev_last);
      end
      if (rd_en_o) chk("outstanding_lt2", (issued - accepted - (hs ? 1 : 0)) < 2, 1);
      if (hs) begin
        if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("byte_data", byte_data_o, e.data);
          chk("byte_last", byte_last_o, e.last);
          chk("msg_id", msg_id_o, e.id);
        end
        accepted++;
      end
      if (rd_en_o) issued++;
      if (release_valid_o) begin
        if (rel_q.size() == 0) chk("extra_release", rel_q.size(), 1);
        else chk("release_addr", release_addr_o, rel_q.pop_front());
      end
      prev_stall = byte_valid_o && !byte_ready_i;
      prev_data = byte_data_o;
      prev_last = byte_last_o;
      pend = rd_en_o;
      pend_addr = rd_addr_o;
    end
  end

  task automatic st(input int slot, input int s, input int en, input bit split, input bit keep);
    slot_i = SW'(slot);
    start_addr_i = DW'(s);
    end_addr_i = DW'(en);
    if (split) begin
      store_start_i = 1'b1;
      @(posedge clk); #1;
      store_start_i = 1'b0;
    end
    store_start_i = !split;
    store_end_i = 1'b1;
    if (keep) begin
      for (int n = 0; n < 2**DW; n++) begin
        int a;
        a = (s + n) % (2**DW);
        exp_q.push_back({SW'(slot), a == en, mem[a]});
        if (a == en) break;
      end
      rel_q.push_back(DW'(en + 1));
    end
    @(posedge clk); #1;
    store_start_i = 1'b0;
    store_end_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rel_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2**DW; i++) mem[i] = 8'(i * 37 + 11);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", tbl_empty_o, 1);
    chk("rst_full", tbl_full_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rd_en", rd_en_o, 0);
    chk("rst_bvalid", byte_valid_o, 0);
    chk("rst_release", release_valid_o, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    // basic message with latency check
    st(0, 3, 6, 1, 1);
    @(negedge clk) chk("lat_rd_en_t1", rd_en_o, 0);
    @(negedge clk) begin
      chk("lat_rd_en_t2", rd_en_o, 1);
      chk("lat_rd_addr", rd_addr_o, 3);
      chk("lat_bvalid_t2", byte_valid_o, 0);
    end
    @(negedge clk) chk("lat_bvalid_t3", byte_valid_o, 1);
    wait_done(200);
    // wrap-around message
    st(1, 30, 1, 0, 1);
    wait_done(200);
    // single byte message
    st(2, 9, 9, 0, 1);
    wait_done(200);
    chk("t3_empty", tbl_empty_o, 1);
    // stalled downstream
    mode = 2;
    st(3, 12, 15, 0, 1);
    wait_done(300);
    // fill the table, then drop a store to a complete slot
    mode = 1;
    for (int k = 0; k < NS; k++) st((4 + k) % NS, k * 4, k * 4 + (k % 3), 0, 1);
    @(negedge clk) begin
      chk("t5_full", tbl_full_o, 1);
      chk("t5_not_empty", tbl_empty_o, 0);
      chk("t5_err_clear", err_o, 0);
    end
    @(posedge clk); #1;
    st(2, 20, 21, 0, 0);
    @(negedge clk) chk("t5_err_set", err_o, 1);
    mode = 0;
    wait_done(600);
    chk("t5_empty", tbl_empty_o, 1);
    chk("t5_full_clear", tbl_full_o, 0);
    chk("t5_err_sticky", err_o, 1);
    // reset in the middle of a long message
    st(4, 0, 15, 0, 1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rd_en", rd_en_o, 0);
    chk("t6_bvalid", byte_valid_o, 0);
    chk("t6_bdata", byte_data_o, 0);
    chk("t6_release", release_valid_o, 0);
    chk("t6_rel_addr", release_addr_o, 0);
    chk("t6_empty", tbl_empty_o, 1);
    chk("t6_err", err_o, 0);
    chk("t6_msg_id", msg_id_o, 0);
    exp_q.delete();
    rel_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    st(0, 5, 8, 0, 1);
    wait_done(200);
    chk("t6_empty_after", tbl_empty_o, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
